// File: rtl/uart_alu_sequencer_pkg.sv
// Shared widths, timeout default and one-hot state encoding for the UART-to-ALU sequencer.
package uart_alu_sequencer_pkg;

  localparam int unsigned WIDTH_WORD             = 8;
  localparam int unsigned WIDTH_OPCODE           = 6;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  typedef enum logic [4:0] {
    StWaitA  = 5'b00001,
    StWaitB  = 5'b00010,
    StWaitOp = 5'b00100,
    StExec   = 5'b01000,
    StWaitTx = 5'b10000
  } state_e;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle of rx/alu/tx signals seen by the sequencer; slave is the sequencer side.
interface uart_alu_sequencer_if;
  import uart_alu_sequencer_pkg::*;

  logic                    i_rx_done;
  logic [WIDTH_WORD-1:0]   i_data_rx;
  logic [WIDTH_WORD-1:0]   i_alu_result;
  logic                    i_tx_done;
  logic [WIDTH_WORD-1:0]   o_dato_a;
  logic [WIDTH_WORD-1:0]   o_dato_b;
  logic [WIDTH_OPCODE-1:0] o_opcode;
  logic                    o_tx_start;
  logic [WIDTH_WORD-1:0]   o_data_tx;
  logic                    o_busy;
  logic                    o_error;

  modport slave (
    input  i_rx_done, i_data_rx, i_alu_result, i_tx_done,
    output o_dato_a, o_dato_b, o_opcode, o_tx_start, o_data_tx, o_busy, o_error
  );

  modport master (
    output i_rx_done, i_data_rx, i_alu_result, i_tx_done,
    input  o_dato_a, o_dato_b, o_opcode, o_tx_start, o_data_tx, o_busy, o_error
  );

endinterface

// File: rtl/edge_detector_rise.sv
// Rising-edge detector for level strobes arriving from the baud-rate domain.
module edge_detector_rise (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_pulse
);

  logic level_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_level;
    end
  end

  assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from rx, runs the ALU for one cycle,
// then hands the result to tx. An inter-byte timeout resynchronises a broken frame.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  uart_alu_sequencer_if.slave  bus
);

  localparam int unsigned     CntW      = cnt_width(TIMEOUT_CYCLES);
  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  logic rx_edge;
  logic tx_edge;

  edge_detector_rise u_rx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (bus.i_rx_done),
    .o_pulse (rx_edge)
  );

  edge_detector_rise u_tx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (bus.i_tx_done),
    .o_pulse (tx_edge)
  );

  state_e                  state_q,    state_d;
  logic [WIDTH_WORD-1:0]   dato_a_q,   dato_a_d;
  logic [WIDTH_WORD-1:0]   dato_b_q,   dato_b_d;
  logic [WIDTH_OPCODE-1:0] opcode_q,   opcode_d;
  logic [WIDTH_WORD-1:0]   data_tx_q,  data_tx_d;
  logic                    tx_start_q, tx_start_d;
  logic                    error_q,    error_d;
  logic [CntW-1:0]         cnt_q,      cnt_d;
  logic                    expire;

  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    opcode_d   = opcode_q;
    data_tx_d  = data_tx_q;
    tx_start_d = 1'b0;
    error_d    = 1'b0;
    cnt_d      = '0;
    expire     = TimeoutEn && (cnt_q == CntLast);

    unique case (state_q)
      StWaitA: begin
        if (rx_edge) begin
          dato_a_d = bus.i_data_rx;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        // An arriving byte wins over a simultaneous expiry.
        if (rx_edge) begin
          dato_b_d = bus.i_data_rx;
          state_d  = StWaitOp;
        end else if (expire) begin
          error_d = 1'b1;
          state_d = StWaitA;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitOp: begin
        if (rx_edge) begin
          opcode_d = bus.i_data_rx[WIDTH_OPCODE-1:0];
          state_d  = StExec;
        end else if (expire) begin
          error_d = 1'b1;
          state_d = StWaitA;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StExec: begin
        // The ALU has had one full cycle with the new opcode by now.
        data_tx_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
        error_d    = rx_edge;
      end
      StWaitTx: begin
        error_d = rx_edge;
        if (tx_edge) begin
          state_d = StWaitA;
        end
      end
      default: begin
        state_d = StWaitA;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StWaitA;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= '0;
      data_tx_q  <= '0;
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      opcode_q   <= opcode_d;
      data_tx_q  <= data_tx_d;
      tx_start_q <= tx_start_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_dato_a   = dato_a_q;
  assign bus.o_dato_b   = dato_b_q;
  assign bus.o_opcode   = opcode_q;
  assign bus.o_data_tx  = data_tx_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_error    = error_q;
  assign bus.o_busy     = (state_q == StExec) || (state_q == StWaitTx);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomised self-checking bench: one DUT with the default timeout, one with a 50-cycle timeout.
module tb_uart_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic       tx_done = 1'b0;
  bit         sel = 1'b0;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_tx = 0, last_tx_cyc = -1;
  int n_err = 0, last_err_cyc = -1, n_long = 0;
  logic [7:0] last_tx_data = 8'h00;
  logic prev_err = 1'b0;

  uart_alu_sequencer_if bus_m ();
  uart_alu_sequencer_if bus_t ();

  assign bus_m.i_rx_done    = rx_done;
  assign bus_m.i_data_rx    = data_rx;
  assign bus_m.i_tx_done    = tx_done;
  assign bus_m.i_alu_result = bus_m.o_dato_a + bus_m.o_dato_b;
  assign bus_t.i_rx_done    = rx_done;
  assign bus_t.i_data_rx    = data_rx;
  assign bus_t.i_tx_done    = tx_done;
  assign bus_t.i_alu_result = bus_t.o_dato_a + bus_t.o_dato_b;

  uart_alu_sequencer #(.TIMEOUT_CYCLES(1000000)) u_dut_m (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_m)
  );

  uart_alu_sequencer #(.TIMEOUT_CYCLES(50)) u_dut_t (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_t)
  );

  logic [7:0] obs_a, obs_b, obs_data_tx;
  logic [5:0] obs_op;
  logic       obs_tx_start, obs_busy, obs_err;

  assign obs_a        = sel ? bus_t.o_dato_a   : bus_m.o_dato_a;
  assign obs_b        = sel ? bus_t.o_dato_b   : bus_m.o_dato_b;
  assign obs_op       = sel ? bus_t.o_opcode   : bus_m.o_opcode;
  assign obs_data_tx  = sel ? bus_t.o_data_tx  : bus_m.o_data_tx;
  assign obs_tx_start = sel ? bus_t.o_tx_start : bus_m.o_tx_start;
  assign obs_busy     = sel ? bus_t.o_busy     : bus_m.o_busy;
  assign obs_err      = sel ? bus_t.o_error    : bus_m.o_error;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder on the selected DUT; cyc is the index of the posedge just past.
  always @(negedge clk) begin
    if (obs_tx_start) begin
      n_tx++;
      last_tx_cyc  = cyc;
      last_tx_data = obs_data_tx;
    end
    if (obs_err) begin
      n_err++;
      last_err_cyc = cyc;
      if (prev_err) n_long++;
    end
    prev_err = obs_err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise rx_done for hold clocks; acc_cyc is the posedge that sees the edge.
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_rx = b;
    rx_done = 1'b1;
    acc_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic finish_tx();
    int tx0;
    tx0 = n_tx;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    nvec++;
    if (obs_busy !== 1'b0) begin
      nmis++; $display("FAIL tx_done_busy: got %b want 0", obs_busy);
    end
    repeat (3) @(negedge clk);
    tx_done = 1'b0;
    nvec++;
    if (n_tx !== tx0) begin
      nmis++; $display("FAIL tx_level_retrigger: got %0d tx pulses want %0d", n_tx, tx0);
    end
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int hold, input bit finish);
    int tx0, err0, opc;
    logic [7:0] exp_res;
    logic [5:0] exp_op;
    tx0 = n_tx; err0 = n_err;
    exp_res = 8'((int'(a) + int'(b)) % 256);
    exp_op  = 6'(int'(op) % 64);
    send_byte(a, hold);
    send_byte(b, hold);
    send_byte(op, hold);
    opc = acc_cyc;
    while (cyc < opc + 2) @(negedge clk);
    nvec++;
    if (obs_a !== a) begin nmis++; $display("FAIL frame_a: got %h want %h", obs_a, a); end
    nvec++;
    if (obs_b !== b) begin nmis++; $display("FAIL frame_b: got %h want %h", obs_b, b); end
    nvec++;
    if (obs_op !== exp_op) begin
      nmis++; $display("FAIL frame_opcode: got %h want %h", obs_op, exp_op);
    end
    nvec++;
    if (n_tx !== tx0 + 1) begin
      nmis++; $display("FAIL frame_tx_count: got %0d want %0d", n_tx - tx0, 1);
    end
    nvec++;
    if (last_tx_cyc !== opc + 1) begin
      nmis++; $display("FAIL frame_tx_latency: got cycle %0d want %0d", last_tx_cyc, opc + 1);
    end
    nvec++;
    if (last_tx_data !== exp_res) begin
      nmis++; $display("FAIL frame_tx_data: got %h want %h", last_tx_data, exp_res);
    end
    nvec++;
    if (obs_data_tx !== exp_res) begin
      nmis++; $display("FAIL frame_data_hold: got %h want %h", obs_data_tx, exp_res);
    end
    nvec++;
    if (obs_busy !== 1'b1) begin nmis++; $display("FAIL frame_busy: got %b want 1", obs_busy); end
    nvec++;
    if (n_err !== err0) begin
      nmis++; $display("FAIL frame_error: got %0d errors want 0", n_err - err0);
    end
    if (finish) finish_tx();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    nvec++;
    if ({bus_m.o_dato_a, bus_m.o_dato_b, bus_m.o_opcode, bus_m.o_data_tx} !== 30'd0) begin
      nmis++; $display("FAIL reset_data_m: got %h want 0",
                       {bus_m.o_dato_a, bus_m.o_dato_b, bus_m.o_opcode, bus_m.o_data_tx});
    end
    nvec++;
    if ({bus_m.o_tx_start, bus_m.o_busy, bus_m.o_error} !== 3'b000) begin
      nmis++; $display("FAIL reset_flags_m: got %b want 000",
                       {bus_m.o_tx_start, bus_m.o_busy, bus_m.o_error});
    end
    nvec++;
    if ({bus_t.o_dato_a, bus_t.o_dato_b, bus_t.o_opcode, bus_t.o_data_tx,
         bus_t.o_tx_start, bus_t.o_busy, bus_t.o_error} !== 33'd0) begin
      nmis++; $display("FAIL reset_all_t: got nonzero outputs want 0");
    end
  endtask

  task automatic test_normal_frame();
    sel = 1'b0;
    do_reset();
    do_frame(8'h05, 8'h03, 8'h20, 16, 1'b1);
  endtask

  task automatic test_level_hold();
    int tx0;
    sel = 1'b0;
    do_reset();
    tx0 = n_tx;
    send_byte(8'h11, 200);
    @(negedge clk);
    nvec++;
    if (obs_a !== 8'h11) begin nmis++; $display("FAIL hold_a: got %h want 11", obs_a); end
    nvec++;
    if (obs_b !== 8'h00 || obs_op !== 6'h00) begin
      nmis++; $display("FAIL hold_b_op: got %h/%h want 00/00", obs_b, obs_op);
    end
    // Next byte must land in B, proving the block sat in WAIT_B.
    send_byte(8'h22, 2);
    @(negedge clk);
    nvec++;
    if (obs_b !== 8'h22 || obs_a !== 8'h11) begin
      nmis++; $display("FAIL hold_next_b: got a=%h b=%h want a=11 b=22", obs_a, obs_b);
    end
    nvec++;
    if (n_tx !== tx0) begin nmis++; $display("FAIL hold_no_tx: got %0d want 0", n_tx - tx0); end
    send_byte(8'h05, 4);
    nvec++;
    if (last_tx_data !== 8'h33 || n_tx !== tx0 + 1) begin
      nmis++; $display("FAIL hold_result: got %h/%0d want 33/1", last_tx_data, n_tx - tx0);
    end
    finish_tx();
  endtask

  task automatic test_timeout();
    int err0, acc;
    sel = 1'b1;
    do_reset();
    err0 = n_err;
    send_byte(8'h07, 1);
    acc = acc_cyc;
    while (cyc < acc + 52) @(negedge clk);
    nvec++;
    if (n_err !== err0 + 1) begin
      nmis++; $display("FAIL timeout_count: got %0d errors want 1", n_err - err0);
    end
    nvec++;
    if (last_err_cyc !== acc + 50) begin
      nmis++; $display("FAIL timeout_cycle: got %0d want %0d", last_err_cyc - acc, 50);
    end
    nvec++;
    if (n_long !== 0) begin nmis++; $display("FAIL timeout_pulse_len: got %0d want 0", n_long); end
    nvec++;
    if (obs_a !== 8'h07 || obs_busy !== 1'b0) begin
      nmis++; $display("FAIL timeout_hold_a: got a=%h busy=%b want 07/0", obs_a, obs_busy);
    end
    do_frame(8'h02, 8'h02, 8'h20, 2, 1'b1);
  endtask

  task automatic test_edge_at_expiry();
    int err0, acc;
    sel = 1'b1;
    do_reset();
    err0 = n_err;
    send_byte(8'h09, 1);
    acc = acc_cyc;
    while (cyc < acc + 48) @(negedge clk);
    send_byte(8'h0A, 1);
    nvec++;
    if (acc_cyc !== acc + 50) begin
      nmis++; $display("FAIL expiry_align: got %0d want %0d", acc_cyc - acc, 50);
    end
    repeat (4) @(negedge clk);
    nvec++;
    if (obs_b !== 8'h0A) begin nmis++; $display("FAIL expiry_accept: got %h want 0a", obs_b); end
    nvec++;
    if (n_err !== err0) begin
      nmis++; $display("FAIL expiry_no_error: got %0d errors want 0", n_err - err0);
    end
    send_byte(8'h01, 1);
    repeat (3) @(negedge clk);
    nvec++;
    if (obs_data_tx !== 8'h13) begin
      nmis++; $display("FAIL expiry_result: got %h want 13", obs_data_tx);
    end
    finish_tx();
  endtask

  task automatic test_dropped_byte();
    int err0, acc;
    sel = 1'b0;
    do_reset();
    do_frame(8'h31, 8'h42, 8'h1C, 3, 1'b0);
    err0 = n_err;
    send_byte(8'hAA, 3);
    acc = acc_cyc;
    repeat (2) @(negedge clk);
    nvec++;
    if (n_err !== err0 + 1 || last_err_cyc !== acc) begin
      nmis++; $display("FAIL drop_error: got %0d at %0d want 1 at %0d", n_err - err0,
                       last_err_cyc, acc);
    end
    nvec++;
    if (n_long !== 0) begin nmis++; $display("FAIL drop_pulse_len: got %0d want 0", n_long); end
    nvec++;
    if (obs_a !== 8'h31 || obs_b !== 8'h42 || obs_op !== 6'h1C || obs_data_tx !== 8'h73) begin
      nmis++; $display("FAIL drop_regs: got %h %h %h %h want 31 42 1c 73", obs_a, obs_b, obs_op,
                       obs_data_tx);
    end
    nvec++;
    if (obs_busy !== 1'b1) begin nmis++; $display("FAIL drop_busy: got %b want 1", obs_busy); end
    finish_tx();
    do_frame(8'h0F, 8'hF0, 8'h3F, 2, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    do_reset();
    do_frame(8'h5A, 8'h33, 8'h07, 2, 1'b1);
    send_byte(8'h44, 2);
    send_byte(8'h55, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({obs_a, obs_b, obs_op, obs_data_tx, obs_tx_start, obs_busy, obs_err} !== 33'd0) begin
      nmis++; $display("FAIL midreset_outputs: got %h %h %h %h %b%b%b want all 0", obs_a,
                       obs_b, obs_op, obs_data_tx, obs_tx_start, obs_busy, obs_err);
    end
    rst = 1'b0;
    do_frame(8'h10, 8'h20, 8'hFF, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, op;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = 8'($urandom_range(0, 255));
      // A tx_done outside WAIT_TX must not disturb the next frame.
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
      end
      do_frame(a, b, op, int'($urandom_range(1, 8)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_level_hold();
    test_timeout();
    test_edge_at_expiry();
    test_dropped_byte();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
